pll_pwr_seq: RTL and testbench



---
 rtl/pll_pwr_seq_pkg.sv | 27 ++
 rtl/pll_pwr_seq_if.sv | 43 ++++
 rtl/pll_pwr_seq_sync2.sv | 22 ++
 rtl/pll_pwr_seq.sv | 161 ++++++++++++++++
 tb/tb_pll_pwr_seq.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_pwr_seq_pkg.sv
// Shared types and defaults for the PLL power sequencer.
// Optional statistics counters are enabled with the PLL_SEQ_STATS_EN macro.
package pll_seq_pkg;

   // Sequencer states, 3-bit encoding
   typedef enum logic [2:0] {
      S_RST    = 3'd0,
      S_LOCK   = 3'd1,
      S_SWITCH = 3'd2,
      S_RUN    = 3'd3,
      S_BYP    = 3'd4,
      S_SLEEP  = 3'd5,
      S_FAIL   = 3'd6
   } state_t;

   // Default timing constants, in reference-clock cycles
   localparam int RESET_CYCLES_DEF  = 8;
   localparam int SETTLE_CYCLES_DEF = 16;
   localparam int LOCK_TIMEOUT_DEF  = 4096;
   localparam int CNT_W_DEF         = 13;

   // Saturating 16-bit increment for the event counters
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pll_pwr_seq_if.sv
// Control/status bundle between the SoC and the PLL sequencer.
// Optional statistics signals appear when PLL_SEQ_STATS_EN is defined.
//
// Handshake: sleep_req/sleep_ack are a level handshake. The CPU raises
// sleep_req while in WFI; the sequencer raises sleep_ack only once the PLL is
// frozen in bypass. Dropping sleep_req or raising wake withdraws the request;
// sleep_ack then falls on the next cycle. wake always wins over sleep_req.
// retry is a one-cycle pulse and only acts while the sequencer has failed.
interface pll_pwr_seq_if;
   import pll_seq_pkg::*;

   logic   sleep_req;
   logic   wake;
   logic   retry;
   logic   pll_lock;
   logic   pll_resetb;
   logic   pll_bypass;
   logic   pll_latch;
   logic   clk_ok;
   logic   sleep_ack;
   logic   lock_err;
   state_t seq_state;

`ifdef PLL_SEQ_STATS_EN
   logic [15:0] sleep_cnt;
   logic [15:0] relock_cnt;

   modport master (output sleep_req, wake, retry, pll_lock,
                   input  pll_resetb, pll_bypass, pll_latch, clk_ok,
                          sleep_ack, lock_err, seq_state, sleep_cnt, relock_cnt);
   modport slave  (input  sleep_req, wake, retry, pll_lock,
                   output pll_resetb, pll_bypass, pll_latch, clk_ok,
                          sleep_ack, lock_err, seq_state, sleep_cnt, relock_cnt);
`else
   modport master (output sleep_req, wake, retry, pll_lock,
                   input  pll_resetb, pll_bypass, pll_latch, clk_ok,
                          sleep_ack, lock_err, seq_state);
   modport slave  (input  sleep_req, wake, retry, pll_lock,
                   output pll_resetb, pll_bypass, pll_latch, clk_ok,
                          sleep_ack, lock_err, seq_state);
`endif

endinterface

// File: rtl/pll_pwr_seq_sync2.sv
// Two-flop synchroniser for the asynchronous PLL LOCK signal.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the raw input through two flops; both clear to 0 on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_pwr_seq.sv
// Sequencer for the iCE40 hard PLL: power-up reset, lock acquisition,
// WFI sleep/wake handshake and lock-loss recovery. All outputs registered.
// Define PLL_SEQ_STATS_EN to add the sleep_cnt/relock_cnt event counters.
import pll_seq_pkg::*;

module pll_pwr_seq #(
   parameter int RESET_CYCLES  = RESET_CYCLES_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic           clk_ref,
   input  logic           rst_n,
   pll_pwr_seq_if.slave   bus
);

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lock_s;
   logic             resetb_q, bypass_q, latch_q, clk_ok_q, ack_q, err_q;
`ifdef PLL_SEQ_STATS_EN
   logic [15:0]      sleep_cnt_q, relock_cnt_q;
`endif

   sync2 u_lock_sync (
      .clk   (clk_ref),
      .rst_n (rst_n),
      .d     (bus.pll_lock),
      .q     (lock_s)
   );

   // Sequencer FSM with shared counter; counter clears on every state entry
   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_RST;
         cnt      <= '0;
         resetb_q <= 1'b0;
         bypass_q <= 1'b1;
         latch_q  <= 1'b0;
         clk_ok_q <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
`ifdef PLL_SEQ_STATS_EN
         sleep_cnt_q  <= '0;
         relock_cnt_q <= '0;
`endif
      end else begin
         case (state)
            S_RST: begin
               resetb_q <= 1'b0;
               bypass_q <= 1'b1;
               if (cnt == RST_LAST) begin
                  resetb_q <= 1'b1;
                  state    <= S_LOCK;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_LOCK: begin
               // sleep_req is deliberately ignored until the PLL is clean
               if (lock_s) begin
                  bypass_q <= 1'b0;
                  state    <= S_SWITCH;
                  cnt      <= '0;
               end else if (cnt == TMO_LAST) begin
                  err_q <= 1'b1;
                  state <= S_FAIL;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_SWITCH: begin
               if (!lock_s) begin
                  bypass_q <= 1'b1;
                  state    <= S_LOCK;
                  cnt      <= '0;
               end else if (cnt == SET_LAST) begin
                  clk_ok_q <= 1'b1;
                  state    <= S_RUN;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_RUN: begin
               if (!lock_s) begin
                  clk_ok_q <= 1'b0;
                  bypass_q <= 1'b1;
                  state    <= S_LOCK;
                  cnt      <= '0;
`ifdef PLL_SEQ_STATS_EN
                  relock_cnt_q <= sat_inc16(relock_cnt_q);
`endif
               end else if (!bus.wake && bus.sleep_req) begin
                  clk_ok_q <= 1'b0;
                  bypass_q <= 1'b1;
                  state    <= S_BYP;
                  cnt      <= '0;
               end
            end
            S_BYP: begin
               if (bus.wake || !bus.sleep_req) begin
                  state <= S_LOCK;
                  cnt   <= '0;
               end else if (cnt == SET_LAST) begin
                  latch_q <= 1'b1;
                  ack_q   <= 1'b1;
                  state   <= S_SLEEP;
                  cnt     <= '0;
`ifdef PLL_SEQ_STATS_EN
                  sleep_cnt_q <= sat_inc16(sleep_cnt_q);
`endif
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_SLEEP: begin
               // PLL is not reset on wake; relock goes through S_LOCK/S_SWITCH
               if (bus.wake || !bus.sleep_req) begin
                  latch_q <= 1'b0;
                  ack_q   <= 1'b0;
                  state   <= S_LOCK;
                  cnt     <= '0;
               end
            end
            S_FAIL: begin
               if (bus.retry) begin
                  err_q    <= 1'b0;
                  resetb_q <= 1'b0;
                  state    <= S_RST;
                  cnt      <= '0;
               end
            end
            default: begin
               state <= S_RST;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.pll_resetb = resetb_q;
   assign bus.pll_bypass = bypass_q;
   assign bus.pll_latch  = latch_q;
   assign bus.clk_ok     = clk_ok_q;
   assign bus.sleep_ack  = ack_q;
   assign bus.lock_err   = err_q;
   assign bus.seq_state  = state;
`ifdef PLL_SEQ_STATS_EN
   assign bus.sleep_cnt  = sleep_cnt_q;
   assign bus.relock_cnt = relock_cnt_q;
`endif

endmodule

// File: tb/tb_pll_pwr_seq.sv
// Bench for pll_pwr_seq. Stimulus tasks compute, from the sequencing rules,
// the cycle at which each output change must appear and queue it; a monitor
// pops one entry per observed output change and compares value and cycle.
// Output vector bit order: {resetb, bypass, latch, clk_ok, sleep_ack, lock_err}.
module tb_pll_pwr_seq;
   import pll_seq_pkg::*;

   logic clk;
   logic rst_n;
   pll_pwr_seq_if bus();

   pll_pwr_seq dut (
      .clk_ref (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave)
   );

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   bit          mon_en   = 0;
   logic [37:0] exp_q[$];
   logic [5:0]  prev_vec;

   localparam logic [5:0] V_RESET  = 6'b010000;
   localparam logic [5:0] V_LOCK   = 6'b110000;
   localparam logic [5:0] V_SWITCH = 6'b100000;
   localparam logic [5:0] V_RUN    = 6'b100100;
   localparam logic [5:0] V_SLEEP  = 6'b111010;
   localparam logic [5:0] V_FAIL   = 6'b110001;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic logic [5:0] out_vec();
      return {bus.pll_resetb, bus.pll_bypass, bus.pll_latch,
              bus.clk_ok, bus.sleep_ack, bus.lock_err};
   endfunction

   task automatic check(input string name, input logic [37:0] act, input logic [37:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int t, input logic [5:0] v);
      exp_q.push_back({32'(t), v});
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick(1);
   endtask

   task automatic finish_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin : monitor
      logic [5:0]  v;
      logic [37:0] e;
      if (mon_en) begin
         v = out_vec();
         check("invariants", {35'd0, bus.clk_ok & bus.pll_bypass,
                              bus.pll_latch & ~bus.pll_bypass,
                              bus.sleep_ack & bus.clk_ok}, 38'd0);
         if (v != prev_vec) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_change actual=%b required=%b (cycle %0d)", v, prev_vec, cyc);
            end else begin
               e = exp_q.pop_front();
               check("event_vec", {32'd0, v}, {32'd0, e[5:0]});
               check("event_cycle", 38'(cyc), {6'd0, e[37:6]});
            end
            prev_vec = v;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic sleep_wake(input int hold);
      int s, w;
      s = cyc;
      bus.sleep_req = 1'b1;
      push(s + 1, V_LOCK);
      push(s + 17, V_SLEEP);
      w = s + 18 + hold;
      wait_until(w);
      bus.wake      = 1'b1;
      bus.sleep_req = 1'b0;
      push(w + 1, V_LOCK);
      push(w + 2, V_SWITCH);
      push(w + 18, V_RUN);
      tick(1);
      bus.wake = 1'b0;
      wait_until(w + 20);
   endtask

   task automatic simultaneous(input int hold);
      int a, b;
      a = cyc;
      bus.wake      = 1'b1;
      bus.sleep_req = 1'b1;
      wait_until(a + hold);
      check("sim_stay_clk_ok", {37'd0, bus.clk_ok}, 38'd1);
      b = cyc;
      bus.wake = 1'b0;
      push(b + 1, V_LOCK);
      wait_until(b + 6);
      bus.wake = 1'b1;
      push(b + 8, V_SWITCH);
      push(b + 24, V_RUN);
      tick(1);
      bus.wake      = 1'b0;
      bus.sleep_req = 1'b0;
      wait_until(b + 26);
   endtask

   task automatic lock_loss(input int gap);
      int d, r;
      d = cyc;
      bus.pll_lock = 1'b0;
      push(d + 3, V_LOCK);
      r = d + gap;
      wait_until(r);
      bus.pll_lock = 1'b1;
      push(r + 3, V_SWITCH);
      push(r + 19, V_RUN);
      wait_until(r + 21);
   endtask

   task automatic timeout_retry(input int extra, input int lock_dly);
      int d, t, l;
      d = cyc;
      bus.pll_lock = 1'b0;
      push(d + 3, V_LOCK);
      push(d + 3 + LOCK_TIMEOUT_DEF, V_FAIL);
      wait_until(d + 3 + LOCK_TIMEOUT_DEF + extra);
      t = cyc;
      bus.retry = 1'b1;
      push(t + 1, V_RESET);
      push(t + 1 + RESET_CYCLES_DEF, V_LOCK);
      tick(1);
      bus.retry = 1'b0;
      l = t + lock_dly;
      wait_until(l);
      bus.pll_lock = 1'b1;
      push(l + 3, V_SWITCH);
      push(l + 19, V_RUN);
      wait_until(l + 21);
   endtask

   task automatic reset_mid_sleep();
      int s, z, c1;
      s = cyc;
      bus.sleep_req = 1'b1;
      push(s + 1, V_LOCK);
      push(s + 17, V_SLEEP);
      wait_until(s + 20);
      z = cyc;
      #2;
      push(z, V_RESET);
      rst_n = 1'b0;
      #1;
      check("rst_async_latch",  {37'd0, bus.pll_latch},  38'd0);
      check("rst_async_ack",    {37'd0, bus.sleep_ack},  38'd0);
      check("rst_async_resetb", {37'd0, bus.pll_resetb}, 38'd0);
      check("rst_async_bypass", {37'd0, bus.pll_bypass}, 38'd1);
      bus.sleep_req = 1'b0;
      tick(3);
`ifdef PLL_SEQ_STATS_EN
      check("stats_reset", {6'd0, bus.sleep_cnt, bus.relock_cnt}, 38'd0);
`endif
      c1 = cyc;
      rst_n = 1'b1;
      push(c1 + 8, V_LOCK);
      push(c1 + 9, V_SWITCH);
      push(c1 + 25, V_RUN);
      wait_until(c1 + 28);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      checks++;
      failures++;
      $display("FAIL watchdog actual=timeout required=completion (cycle %0d)", cyc);
      finish_run();
   end

   // ---------------- main stimulus ----------------
   initial begin
      int c0, l;
      rst_n         = 1'b0;
      bus.sleep_req = 1'b0;
      bus.wake      = 1'b0;
      bus.retry     = 1'b0;
      bus.pll_lock  = 1'b0;
      tick(2);
      check("reset_outputs", {32'd0, out_vec()}, {32'd0, V_RESET});
      check("reset_state", 38'(bus.seq_state), 38'(S_RST));
      prev_vec = V_RESET;
      mon_en   = 1'b1;

      // power-up: lock arrives 100 cycles after reset release
      c0    = cyc;
      rst_n = 1'b1;
      push(c0 + RESET_CYCLES_DEF, V_LOCK);
      l = c0 + 100;
      wait_until(l);
      bus.pll_lock = 1'b1;
      push(l + 3, V_SWITCH);
      push(l + 19, V_RUN);
      wait_until(l + 22);

      // retry outside S_FAIL must do nothing
      bus.retry = 1'b1;
      tick(1);
      bus.retry = 1'b0;
      tick(5);

      for (int i = 0; i < 3; i++) sleep_wake($urandom_range(0, 30));
`ifdef PLL_SEQ_STATS_EN
      check("sleep_cnt", {22'd0, bus.sleep_cnt}, 38'd3);
`endif

      simultaneous($urandom_range(5, 20));

      lock_loss($urandom_range(5, 40));
`ifdef PLL_SEQ_STATS_EN
      check("relock_cnt", {22'd0, bus.relock_cnt}, 38'd1);
`endif

      timeout_retry($urandom_range(2, 20), $urandom_range(10, 30));

      reset_mid_sleep();

      tick(10);
      check("queue_drained", 38'(exp_q.size()), 38'd0);
      mon_en = 1'b0;
      finish_run();
   end

endmodule
